led7219_rx: RTL
===============

Name: led7219_rx

Overview:
- Receiver/decoder for the MAX7219-style 4-device daisy-chain serial link (DIN/CLK/LOAD) driven by the LED transmitter.
- Oversamples the three link wires on the system clock, shifts in 16-bit words and applies them on the LOAD rising edge.
- Maintains a per-device register image (digit rows, intensity, scan limit, shutdown, test, decode mode).
- Used as an on-chip loopback checker and as the simulation model for LED display verification.

Parameters:
- NUM_DEV, 4, devices in the chain; a frame is NUM_DEV*16 bits.
- SYNC_STAGES, 2, synchronizer depth on din/sclk/cs (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data, MSB first, sampled on sclk rising edge
- sclk  in  1  serial clock; high and low phases each at least SYNC_STAGES+2 clk
- cs  in  1  LOAD, active low; rising edge latches the frame
- fb  out  64*NUM_DEV  digit-row image; same layout as the transmitter's data input
- intensity  out  4*NUM_DEV  register 0xA per device, device k at [4k+3:4k]
- scan_limit  out  3*NUM_DEV  register 0xB
- decode_mode  out  8*NUM_DEV  register 0x9
- shutdown_n  out  NUM_DEV  register 0xC bit 0
- test  out  NUM_DEV  register 0xF bit 0
- frame_valid  out  1  one-cycle pulse when a frame is applied
- frame_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (async, active-high): all outputs 0, including the pulses. Shift register 0. Bit count 0. armed 0. Edge-history registers set to the idle levels: sclk 0, cs 1. Synchronizer flops also reset to the idle levels.
- Synchronized signals are din_s, sclk_s and cs_s. Edges are detected against the previous sample.
- cs_s falling: clear bit count, set armed. Shift-register contents are kept; they are overwritten anyway.
- sclk_s rising while cs_s low and armed: shift din_s into the LSB of a NUM_DEV*16-bit shift register; bit count += 1, saturating at 127.
  - din is sampled from the synchronizer stage aligned with sclk_s.
  - sclk edges while cs_s high or not armed are ignored.
- An sclk_s rising edge and a cs_s rising edge detected in the same cycle: the sclk edge is ignored.
- cs_s rising with armed=1 (detected in cycle N): clear armed, then:
  - If bit count == NUM_DEV*16: in cycle N+1 apply all words and pulse frame_valid. Register outputs are updated in that same cycle.
  - Otherwise: pulse frame_err in N+1 and change no register.
- cs_s rising with armed=0 (e.g. reset released mid-frame): no pulse and no update.
- Word split: word w = shift[16*(NUM_DEV-w)-1 -: 16], w=0 is first shifted. Word w belongs to device index w, where device 0 is the farthest.
- Addressing: addr = word[11:8]; data = word[7:0]; word[15:12] is don't-care.
- Digit address d = 1..8 writes fb[64*NUM_DEV-1 - (d-1)*8*NUM_DEV - w*8 -: 8]. This makes fb equal the transmitter's data input after one full refresh.
- Control addresses:
  - 0x9: decode_mode = data.
  - 0xA: intensity = data[3:0].
  - 0xB: scan_limit = data[2:0].
  - 0xC: shutdown_n = data[0].
  - 0xF: test = data[0].
- Addresses 0x0, 0xD and 0xE are no-ops for that device only. All devices update in the same cycle.
- Reset mid-frame: the partial frame is discarded. The next accepted frame must begin with a cs falling edge.

Decomposition:
- Shared package led7219_pkg holds:
  - Register addresses: REG_NOOP=0, REG_DIGIT0=1…REG_DIGIT7=8, REG_DECODE=9, REG_INTENSITY=10, REG_SCAN=11, REG_SHUTDOWN=12, REG_TEST=15.
  - WORD_W=16 and the fb index function.
  - The transmitter will also use this package.
- One sub-module, led7219_rx_sync: parameterised synchronizer plus edge detector with per-bit reset value, instantiated for cs (reset 1) and sclk (reset 0).
- Frame decode stays in the top module.

Test Plan:
- Transmitter init sequence (0x0B07 x4, 0x0A07 x4, 0x0C01 x4, 0x0F00 x4) → after the 4 frames: intensity=16'h7777, scan_limit=12'hFFF, shutdown_n=4'hF, test=0, frame_valid pulsed 4 times, frame_err never.
- Loopback: transmitter data=256'h0123…CDEF random, run one full 12-state refresh → fb equals data bit-exact; bitbang one frame and check frame_valid rises exactly one clk after cs_s rises.
- Short frame (63 bits) and long frame (65 bits) → frame_err one pulse each, fb/regs unchanged; next correct 64-bit frame applies normally.
- Address upper nibble set (word 16'hF105) and no-op words (16'h00xx) mixed per device → only the addressed devices' row-1 bytes become 8'h05; no-op devices unchanged.
- Assert rst after 30 bits, release with cs still low, clock 34 more bits, raise cs → no pulse, regs 0; following full frame accepted.
- sclk rising edge coincident with cs rising edge after 64 counted bits → frame accepted, extra edge not shifted.

Source files
------------

// File: rtl/led7219_pkg.sv
// -----------------------------------------------------------------------------
// led7219_pkg
// Shared definitions for the MAX7219-style daisy-chain link: register
// addresses, word width and the digit-row placement function for the frame
// buffer image. Shared by the transmitter and the receiver so both agree on
// the frame buffer layout.
// -----------------------------------------------------------------------------
package led7219_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DIGIT1    = 4'h2;
  localparam logic [3:0] REG_DIGIT2    = 4'h3;
  localparam logic [3:0] REG_DIGIT3    = 4'h4;
  localparam logic [3:0] REG_DIGIT4    = 4'h5;
  localparam logic [3:0] REG_DIGIT5    = 4'h6;
  localparam logic [3:0] REG_DIGIT6    = 4'h7;
  localparam logic [3:0] REG_DIGIT7    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  // MSB index in the frame buffer of the byte written by digit address
  // 'digit' (1..8) for chain device 'dev' (0 = farthest from the driver).
  // Digit rows are stored highest row first, and within a row device 0 is
  // the most significant byte.
  function automatic int fb_msb(input int num_dev, input int digit, input int dev);
    return 64*num_dev - 1 - (digit - 1)*8*num_dev - dev*8;
  endfunction

endpackage

// File: rtl/led7219_rx_sync.sv
// -----------------------------------------------------------------------------
// led7219_rx_sync
// Multi-bit synchronizer with edge detection. Every bit goes through the same
// number of stages, so bits sampled together on the pins stay aligned at the
// output. Each bit has its own reset value so the chain and the edge history
// can start at the line's idle level.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_async  asynchronous inputs
//   o_sync   synchronized inputs (last stage)
//   o_rise   o_sync went 0->1 relative to the previous sample
//   o_fall   o_sync went 1->0 relative to the previous sample
// -----------------------------------------------------------------------------
module led7219_rx_sync #(
  parameter int              WIDTH   = 1,
  parameter int              STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_stage [STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_stage[0] <= i_async;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
      r_prev <= r_stage[STAGES-1];
    end
  end

  assign o_sync = r_stage[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/led7219_rx.sv
// -----------------------------------------------------------------------------
// led7219_rx
// Receiver/decoder for a NUM_DEV-long MAX7219-style chain. The DIN/CLK/LOAD
// wires are oversampled on clk; a frame of NUM_DEV 16-bit words is shifted in
// MSB first on sclk rising edges while cs is low, and applied on the cs rising
// edge to a per-device register image.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   din, sclk, cs  serial link (cs = LOAD, active low)
//   fb             digit-row image, 64*NUM_DEV bits (transmitter data layout)
//   intensity      4 bits per device, device k at [4k+3:4k]
//   scan_limit     3 bits per device
//   decode_mode    8 bits per device
//   shutdown_n     1 bit per device
//   test           1 bit per device
//   frame_valid    one-cycle pulse: frame applied (registers updated same cycle)
//   frame_err      one-cycle pulse: frame had the wrong bit count, rejected
//
// Handshake: there is no back-pressure. A frame is bounded by a cs falling
// edge (arms the receiver) and a cs rising edge (commits or rejects). Only an
// armed receiver commits; cs rising while unarmed is silently ignored.
// -----------------------------------------------------------------------------
module led7219_rx
  import led7219_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  sclk,
  input  logic                  cs,
  output logic [64*NUM_DEV-1:0] fb,
  output logic [4*NUM_DEV-1:0]  intensity,
  output logic [3*NUM_DEV-1:0]  scan_limit,
  output logic [8*NUM_DEV-1:0]  decode_mode,
  output logic [NUM_DEV-1:0]    shutdown_n,
  output logic [NUM_DEV-1:0]    test,
  output logic                  frame_valid,
  output logic                  frame_err
);

  localparam int         FRAME_W   = NUM_DEV * WORD_W;
  localparam logic [6:0] CNT_FULL  = 7'(FRAME_W);
  localparam logic [6:0] CNT_MAX   = 7'd127;
  localparam logic [7:0] WARM_LAST = 8'(SYNC_STAGES + 1);

  // ---------------------------------------------------------------------------
  // Synchronizers. din travels with sclk through identical stages so the data
  // bit seen on an sclk_s rising edge is the one present at the pin edge.
  // ---------------------------------------------------------------------------
  logic [1:0] w_ds_sync, w_ds_rise, w_ds_fall;
  logic       w_cs_s, w_cs_rise, w_cs_fall;
  logic       w_din_s, w_sclk_rise;

  led7219_rx_sync #(
    .WIDTH   (2),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (2'b00)
  ) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .i_async ({din, sclk}),
    .o_sync  (w_ds_sync),
    .o_rise  (w_ds_rise),
    .o_fall  (w_ds_fall)
  );

  led7219_rx_sync #(
    .WIDTH   (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .i_async (cs),
    .o_sync  (w_cs_s),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_din_s     = w_ds_sync[1];
  assign w_sclk_rise = w_ds_rise[0];

  logic w_unused;
  assign w_unused = ^{w_ds_sync[0], w_ds_rise[1], w_ds_fall};

  // ---------------------------------------------------------------------------
  // Receive state
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0]     r_shift;
  logic [6:0]             r_cnt;
  logic                   r_armed;
  logic [7:0]             r_warm;

  logic [64*NUM_DEV-1:0]  r_fb;
  logic [4*NUM_DEV-1:0]   r_int;
  logic [3*NUM_DEV-1:0]   r_scan;
  logic [8*NUM_DEV-1:0]   r_dec;
  logic [NUM_DEV-1:0]     r_shdn;
  logic [NUM_DEV-1:0]     r_test;
  logic                   r_fv;
  logic                   r_fe;

  // The synchronizer reset level (cs high) is not a real observation of the
  // line. If cs is actually low when reset is released, the chain drains to
  // 0 and would look like a falling edge, arming on a partial frame. Edges
  // are therefore ignored until the chain and edge history hold real samples.
  logic w_warm_done;
  assign w_warm_done = (r_warm == WARM_LAST);

  // ---------------------------------------------------------------------------
  // Frame decode: next register image if the shift register were applied now.
  // ---------------------------------------------------------------------------
  logic [64*NUM_DEV-1:0]  w_fb_n;
  logic [4*NUM_DEV-1:0]   w_int_n;
  logic [3*NUM_DEV-1:0]   w_scan_n;
  logic [8*NUM_DEV-1:0]   w_dec_n;
  logic [NUM_DEV-1:0]     w_shdn_n;
  logic [NUM_DEV-1:0]     w_test_n;
  logic [WORD_W-1:0]      w_word;

  always_comb begin
    w_fb_n   = r_fb;
    w_int_n  = r_int;
    w_scan_n = r_scan;
    w_dec_n  = r_dec;
    w_shdn_n = r_shdn;
    w_test_n = r_test;
    w_word   = '0;
    // Word 0 was shifted first, so it sits at the top of the shift register
    // and belongs to device 0 (the far end of the chain).
    for (int w = 0; w < NUM_DEV; w++) begin
      w_word = r_shift[WORD_W*(NUM_DEV-w)-1 -: WORD_W];
      case (w_word[11:8])
        REG_DECODE:    w_dec_n[8*w +: 8]  = w_word[7:0];
        REG_INTENSITY: w_int_n[4*w +: 4]  = w_word[3:0];
        REG_SCAN:      w_scan_n[3*w +: 3] = w_word[2:0];
        REG_SHUTDOWN:  w_shdn_n[w]        = w_word[0];
        REG_TEST:      w_test_n[w]        = w_word[0];
        REG_NOOP, 4'hD, 4'hE: ;
        default: begin
          // Remaining addresses are the eight digit rows.
          for (int d = 1; d <= 8; d++) begin
            if (w_word[11:8] == REG_DIGIT0 + 4'(d - 1))
              w_fb_n[fb_msb(NUM_DEV, d, w) -: 8] = w_word[7:0];
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential receive / commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
      r_warm  <= '0;
      r_fb    <= '0;
      r_int   <= '0;
      r_scan  <= '0;
      r_dec   <= '0;
      r_shdn  <= '0;
      r_test  <= '0;
      r_fv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_fe <= 1'b0;
      if (!w_warm_done) r_warm <= r_warm + 8'd1;

      if (w_warm_done && w_cs_fall) begin
        r_cnt   <= '0;
        r_armed <= 1'b1;
      end else if (w_cs_rise) begin
        // A coincident sclk edge is deliberately dropped here.
        if (r_armed) begin
          r_armed <= 1'b0;
          if (r_cnt == CNT_FULL) begin
            r_fb   <= w_fb_n;
            r_int  <= w_int_n;
            r_scan <= w_scan_n;
            r_dec  <= w_dec_n;
            r_shdn <= w_shdn_n;
            r_test <= w_test_n;
            r_fv   <= 1'b1;
          end else begin
            r_fe <= 1'b1;
          end
        end
      end else if (w_sclk_rise && !w_cs_s && r_armed) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_din_s};
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  assign fb          = r_fb;
  assign intensity   = r_int;
  assign scan_limit  = r_scan;
  assign decode_mode = r_dec;
  assign shutdown_n  = r_shdn;
  assign test        = r_test;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;

endmodule
